// File: rtl/adder_result_checker.sv
// Checker behind the 8-bit combinational adder.
// Takes vectors over valid/ready, counts checks and mismatches.
module adder_result_checker #(
    parameter int WIDTH   = 8,
    parameter int NUM_VEC = 25,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_exp,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_y,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] NV  = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] acc_cnt;
    logic [WIDTH:0]   exp_q;
    logic             chk_v;
    logic             xfer;
    logic             cmp_bad;
    logic             last_chk;
    logic             go;
    logic [CNT_W-1:0] err_nx;

    assign in_ready = (state == RUN) && (acc_cnt < NV);
    assign xfer     = in_valid && in_ready;
    // Full-width compare so a wrong carry bit is caught.
    assign cmp_bad  = (add_y != exp_q);
    assign last_chk = (state == RUN) && chk_v
                      && (vec_count == NV - 1'b1);
    assign go       = start && (state != RUN);

    // Saturating error count after the check in flight.
    always_comb begin
        err_nx = err_count;
        if (chk_v && cmp_bad && (err_count != MAX))
            err_nx = err_count + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; start is ignored while running.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_chk) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Accept stage, check stage, counters and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a     <= '0;
            add_b     <= '0;
            exp_q     <= '0;
            chk_v     <= 1'b0;
            acc_cnt   <= '0;
            vec_count <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (go) begin
            chk_v     <= 1'b0;
            acc_cnt   <= '0;
            vec_count <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            chk_v    <= xfer;
            mismatch <= chk_v && cmp_bad;
            if (xfer) begin
                add_a   <= in_a;
                add_b   <= in_b;
                exp_q   <= in_exp;
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (chk_v) begin
                vec_count <= vec_count + 1'b1;
                err_count <= err_nx;
            end
            if (last_chk) begin
                done <= 1'b1;
                pass <= (err_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker.
// Includes a behavioural 8-bit adder on add_a/add_b.
module tb_adder_result_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [8:0] in_exp = '0;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [8:0] add_y;
    logic       mismatch;
    logic [7:0] vec_count;
    logic [7:0] err_count;
    logic       done;
    logic       pass;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign add_y = {1'b0, add_a} + {1'b0, add_b};

    adder_result_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_exp    (in_exp),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_y     (add_y),
        .mismatch  (mismatch),
        .vec_count (vec_count),
        .err_count (err_count),
        .done      (done),
        .pass      (pass)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed 25 vectors (i,i,2i); optional bad index, random gaps,
    // a start pulse at loop cycle smid, a start on the final check edge.
    task automatic feed(input string tag, input int bad, input bit gaps,
                        input int smid, input bit fstart,
                        input int exp_err, input bit exp_pass);
        int i = 0;
        int k = 0;
        int mm = 0;
        int mm_c = -1;
        int bad_c = -2;
        bit v;
        bit rdy;
        while (i < 25 && k < 500) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_a = 8'(i);
            in_b = 8'(i);
            in_exp = (i == bad) ? 9'h000 : 9'(2 * i);
            start = (k == smid);
            rdy = in_ready;
            tick();
            if (v && rdy) begin
                if (i == bad) bad_c = cyc;
                i++;
            end
            if (mismatch) begin
                mm++;
                mm_c = cyc;
            end
            k++;
        end
        start = 1'b0;
        chk({tag, "_accepts"}, 32'(i), 32'd25);
        chk({tag, "_ready_drop"}, 32'(in_ready), 32'd0);
        // Keep offering a vector: it must not be taken.
        in_valid = 1'b1;
        in_a = 8'd1;
        in_b = 8'd1;
        in_exp = 9'd2;
        k = 0;
        while (!done && k < 20) begin
            start = fstart && (k == 0);
            tick();
            start = 1'b0;
            if (mismatch) begin
                mm++;
                mm_c = cyc;
            end
            k++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_vec"}, 32'(vec_count), 32'd25);
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_mm_pulses"}, 32'(mm), 32'(exp_err));
        if (bad >= 0)
            chk({tag, "_mm_time"}, 32'(mm_c), 32'(bad_c + 1));
        tick();
        tick();
        chk({tag, "_hold_vec"}, 32'(vec_count), 32'd25);
        chk({tag, "_hold_done"}, 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_vec", 32'(vec_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_adda", 32'(add_a), 32'd0);
        rst_n = 1'b1;
        tick();
        // IDLE ignores in_valid
        in_valid = 1'b1;
        in_a = 8'd9;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_adda", 32'(add_a), 32'd0);
        in_valid = 1'b0;

        // 1: clean run
        do_start();
        chk("t1_ready", 32'(in_ready), 32'd1);
        feed("t1", -1, 1'b0, -1, 1'b0, 0, 1'b1);

        // 2: vector 7 corrupted
        do_start();
        chk("t2_clear_done", 32'(done), 32'd0);
        feed("t2", 7, 1'b0, -1, 1'b0, 1, 1'b0);

        // 3: random valid gaps
        do_start();
        feed("t3", -1, 1'b1, -1, 1'b0, 0, 1'b1);

        // 4: carry bit checked
        do_start();
        in_valid = 1'b1;
        in_a = 8'd255; in_b = 8'd255; in_exp = 9'h1FE;
        tick();
        in_a = 8'd128; in_b = 8'd128; in_exp = 9'h100;
        tick();
        chk("t4_mm_ff_ff", 32'(mismatch), 32'd0);
        in_a = 8'd255; in_b = 8'd1; in_exp = 9'h0FF;
        tick();
        chk("t4_mm_80_80", 32'(mismatch), 32'd0);
        in_valid = 1'b0;
        in_a = 8'd3;
        tick();
        chk("t4_mm_ff_01", 32'(mismatch), 32'd1);
        chk("t4_err", 32'(err_count), 32'd1);
        chk("t4_vec", 32'(vec_count), 32'd3);
        tick();
        chk("t4_mm_pulse", 32'(mismatch), 32'd0);
        chk("t4_hold_a", 32'(add_a), 32'd255);
        chk("t4_hold_b", 32'(add_b), 32'd1);

        // 5: reset mid-run after 10 accepts
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        do_start();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 8'(i); in_b = 8'(i); in_exp = 9'(2 * i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_ready", 32'(in_ready), 32'd0);
        chk("t5_adda", 32'(add_a), 32'd0);
        chk("t5_addb", 32'(add_b), 32'd0);
        chk("t5_vec", 32'(vec_count), 32'd0);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_mm", 32'(mismatch), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t5_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        do_start();
        feed("t5", -1, 1'b0, -1, 1'b0, 0, 1'b1);

        // 6: start in DONE clears, mid-RUN and final-edge starts ignored
        do_start();
        chk("t6_vec_clr", 32'(vec_count), 32'd0);
        chk("t6_err_clr", 32'(err_count), 32'd0);
        chk("t6_done_clr", 32'(done), 32'd0);
        chk("t6_pass_clr", 32'(pass), 32'd0);
        feed("t6", 4, 1'b0, 12, 1'b1, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
